// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: RV32I opcodes used here and the
// funct3 access-width codes for loads and stores.
package mem_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned BE_W      = 4;

  // Opcodes
  localparam logic [OPCODE_W-1:0] LOAD_OP   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] STORE_OP  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_IMM_OP = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] SYSTEM_OP = 7'b1110011;

  // Load width codes
  localparam logic [FUNCT3_W-1:0] LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] LHU = 3'b101;

  // Store width codes
  localparam logic [FUNCT3_W-1:0] SB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] SH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the MEM stage.
// Store side: byte enables, lane-aligned write data, misalignment flag.
// Load side : lane select from the read word plus sign/zero extension.
// Ports: st_funct3/st_addr_lo/st_data -> be_c, wdata_c, misaligned_c;
//        ld_funct3/ld_addr_lo/ld_rdata -> ld_data_c.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [FUNCT3_W-1:0] st_funct3,
  input  logic [1:0]          st_addr_lo,
  input  logic [XLEN-1:0]     st_data,
  output logic [BE_W-1:0]     be_c,
  output logic [XLEN-1:0]     wdata_c,
  output logic                misaligned_c,
  input  logic [FUNCT3_W-1:0] ld_funct3,
  input  logic [1:0]          ld_addr_lo,
  input  logic [XLEN-1:0]     ld_rdata,
  output logic [XLEN-1:0]     ld_data_c
);

  logic [4:0]      st_shamt;
  logic [4:0]      ld_shamt;
  logic [XLEN-1:0] ld_shifted;

  assign st_shamt   = {st_addr_lo, 3'b000};
  assign ld_shamt   = {ld_addr_lo, 3'b000};
  assign ld_shifted = ld_rdata >> ld_shamt;

  // Width-dependent enables/data; loads reuse the same enable pattern.
  always_comb begin
    be_c         = '0;
    wdata_c      = '0;
    misaligned_c = 1'b1;
    case (st_funct3[1:0])
      2'b00: begin
        be_c         = 4'b0001 << st_addr_lo;
        wdata_c      = {24'd0, st_data[7:0]} << st_shamt;
        misaligned_c = 1'b0;
      end
      2'b01: begin
        be_c         = 4'b0011 << st_addr_lo;
        wdata_c      = {16'd0, st_data[15:0]} << st_shamt;
        misaligned_c = st_addr_lo[0];
      end
      2'b10: begin
        be_c         = 4'b1111;
        wdata_c      = st_data;
        misaligned_c = (st_addr_lo != 2'b00);
      end
      default: begin
        be_c         = '0;
        wdata_c      = '0;
        misaligned_c = 1'b1;
      end
    endcase
  end

  // Lane select and extension of the returned word.
  always_comb begin
    ld_data_c = ld_rdata;
    case (ld_funct3)
      LB:      ld_data_c = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      LH:      ld_data_c = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      LW:      ld_data_c = ld_rdata;
      LBU:     ld_data_c = {24'd0, ld_shifted[7:0]};
      LHU:     ld_data_c = {16'd0, ld_shifted[15:0]};
      default: ld_data_c = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline. Runs LOAD/STORE over a req/ack bus,
// stalls upstream while an access is outstanding, and registers the
// MEM/WB fields feeding the write-back stage.
// Ports: clk/rst; EX/MEM inputs (valid_in, funct3_in, opcode_in, c_in,
// b_in, pc4_in, z_in, rd_in); stall; dmem_* bus; MEM/WB outputs
// (valid_out, funct3_out, opcode_out, c_out, d_out, pc4_out, z_out,
// rd_out); misaligned and bus_err single-cycle pulses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  opcode_in,
  input  logic [31:0] c_in,
  input  logic [31:0] b_in,
  input  logic [31:0] pc4_in,
  input  logic [31:0] z_in,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [2:0]  funct3_out,
  output logic [6:0]  opcode_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out,
  output logic [31:0] pc4_out,
  output logic [31:0] z_out,
  output logic [4:0]  rd_out,
  output logic        misaligned,
  output logic        bus_err
);

  localparam int unsigned CNT_W  = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam bit          TO_EN  = (BUS_TIMEOUT != 0);

  mem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic        stall_d, req_d, we_d, valid_d, mis_d, err_d;
  logic [31:0] addr_d, wdata_d, c_d, d_d, pc4_d, z_d;
  logic [3:0]  be_d;
  logic [2:0]  funct3_d;
  logic [6:0]  opcode_d;
  logic [4:0]  rd_d;

  logic        is_load_in, is_store_in;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_data_c;
  logic        misaligned_c;

  assign is_load_in  = (opcode_in == LOAD_OP);
  assign is_store_in = (opcode_in == STORE_OP);
  assign cnt_inc     = cnt_q + CNT_W'(1);

  // Store side sees the incoming instruction; load side sees the latched one.
  mem_align u_align (
    .st_funct3    (funct3_in),
    .st_addr_lo   (c_in[1:0]),
    .st_data      (b_in),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .misaligned_c (misaligned_c),
    .ld_funct3    (funct3_out),
    .ld_addr_lo   (c_out[1:0]),
    .ld_rdata     (dmem_rdata),
    .ld_data_c    (ld_data_c)
  );

  // State, counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stall      <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      valid_out  <= 1'b0;
      funct3_out <= '0;
      opcode_out <= '0;
      c_out      <= '0;
      d_out      <= '0;
      pc4_out    <= '0;
      z_out      <= '0;
      rd_out     <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall      <= stall_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
      dmem_addr  <= addr_d;
      dmem_be    <= be_d;
      dmem_wdata <= wdata_d;
      valid_out  <= valid_d;
      funct3_out <= funct3_d;
      opcode_out <= opcode_d;
      c_out      <= c_d;
      d_out      <= d_d;
      pc4_out    <= pc4_d;
      z_out      <= z_d;
      rd_out     <= rd_d;
      misaligned <= mis_d;
      bus_err    <= err_d;
    end
  end

  // Next state and next register values. MEM/WB fields double as the
  // latch for an in-flight access since valid_out is low while BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    stall_d  = 1'b0;
    req_d    = 1'b0;
    we_d     = dmem_we;
    addr_d   = dmem_addr;
    be_d     = dmem_be;
    wdata_d  = dmem_wdata;
    valid_d  = 1'b0;
    funct3_d = funct3_out;
    opcode_d = opcode_out;
    c_d      = c_out;
    d_d      = d_out;
    pc4_d    = pc4_out;
    z_d      = z_out;
    rd_d     = rd_out;
    mis_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if ((is_load_in || is_store_in) && misaligned_c) begin
            mis_d = 1'b1;
          end else begin
            funct3_d = funct3_in;
            opcode_d = opcode_in;
            c_d      = c_in;
            d_d      = '0;
            pc4_d    = pc4_in;
            z_d      = z_in;
            rd_d     = rd_in;
            if (is_load_in || is_store_in) begin
              state_d = BUSY;
              stall_d = 1'b1;
              req_d   = 1'b1;
              we_d    = is_store_in;
              addr_d  = {c_in[31:2], 2'b00};
              be_d    = be_c;
              wdata_d = is_store_in ? wdata_c : 32'd0;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          valid_d = 1'b1;
          d_d     = (opcode_out == LOAD_OP) ? ld_data_c : 32'd0;
        end else if (TO_EN && (cnt_inc == CNT_W'(BUS_TIMEOUT))) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
          stall_d = 1'b1;
          req_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (BUS_TIMEOUT = 4).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [2:0]  funct3_in;
  logic [6:0]  opcode_in;
  logic [31:0] c_in, b_in, pc4_in, z_in;
  logic [4:0]  rd_in;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [2:0]  funct3_out;
  logic [6:0]  opcode_out;
  logic [31:0] c_out, d_out, pc4_out, z_out;
  logic [4:0]  rd_out;
  logic        misaligned, bus_err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  always #5 clk = ~clk;

  mem_stage #(.BUS_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .funct3_in  (funct3_in),
    .opcode_in  (opcode_in),
    .c_in       (c_in),
    .b_in       (b_in),
    .pc4_in     (pc4_in),
    .z_in       (z_in),
    .rd_in      (rd_in),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .valid_out  (valid_out),
    .funct3_out (funct3_out),
    .opcode_out (opcode_out),
    .c_out      (c_out),
    .d_out      (d_out),
    .pc4_out    (pc4_out),
    .z_out      (z_out),
    .rd_out     (rd_out),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] c, input logic [31:0] b, input logic [4:0] rd);
    valid_in  = 1'b1;
    opcode_in = opc;
    funct3_in = f3;
    c_in      = c;
    b_in      = b;
    pc4_in    = c + 32'd4;
    z_in      = 32'h5A5A_0000;
    rd_in     = rd;
  endtask

  // Load of a byte at 0x103 with ack in the third BUSY cycle.
  task automatic run_lb(input logic [2:0] f3, input logic [31:0] exp_d, input string tag);
    issue(OPC_LOAD, f3, 32'h0000_0103, 32'h0, 5'd7);
    step();
    valid_in = 1'b0;
    check({tag, "_addr"}, dmem_addr, 32'h0000_0100);
    check({tag, "_be"}, {28'd0, dmem_be}, 32'h8);
    check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    check({tag, "_bubble"}, {31'd0, valid_out}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_stall"}, {31'd0, stall}, 32'd1);
      check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
      if (k == 2) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FFFF;
      end
      step();
    end
    dmem_ack = 1'b0;
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, "_d"}, d_out, exp_d);
    check({tag, "_stall_drop"}, {31'd0, stall}, 32'd0);
    check({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    valid_in   = 1'b0;
    funct3_in  = '0;
    opcode_in  = '0;
    c_in       = '0;
    b_in       = '0;
    pc4_in     = '0;
    z_in       = '0;
    rd_in      = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_err", {30'd0, misaligned, bus_err}, 32'd0);
    rst = 1'b0;
    step();

    // ADD passes straight through with latency 1
    issue(OPC_OP, 3'b000, 32'h0000_1234, 32'h1, 5'd5);
    step();
    check("add_valid", {31'd0, valid_out}, 32'd1);
    check("add_c", c_out, 32'h0000_1234);
    check("add_d", d_out, 32'd0);
    check("add_pc4", pc4_out, 32'h0000_1238);
    check("add_rd", {27'd0, rd_out}, 32'd5);
    check("add_stall", {31'd0, stall}, 32'd0);
    valid_in = 1'b0;
    step();
    check("idle_valid", {31'd0, valid_out}, 32'd0);

    run_lb(3'b000, 32'hFFFF_FF80, "lb");
    run_lb(3'b100, 32'h0000_0080, "lbu");

    // SH at 0x202
    issue(OPC_STORE, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0);
    step();
    valid_in = 1'b0;
    check("sh_addr", dmem_addr, 32'h0000_0200);
    check("sh_be", {28'd0, dmem_be}, 32'hC);
    check("sh_wdata_hi", {16'd0, dmem_wdata[31:16]}, 32'h0000_BEEF);
    check("sh_we", {31'd0, dmem_we}, 32'd1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("sh_valid", {31'd0, valid_out}, 32'd1);
    check("sh_d", d_out, 32'd0);

    // Misaligned LW, then ADD accepted next cycle
    issue(OPC_LOAD, 3'b010, 32'h0000_0102, 32'h0, 5'd3);
    step();
    check("mis_pulse", {31'd0, misaligned}, 32'd1);
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_valid", {31'd0, valid_out}, 32'd0);
    check("mis_stall", {31'd0, stall}, 32'd0);
    issue(OPC_OP, 3'b000, 32'h0000_0055, 32'h0, 5'd4);
    step();
    check("mis_next_valid", {31'd0, valid_out}, 32'd1);
    check("mis_next_c", c_out, 32'h0000_0055);
    check("mis_pulse_end", {31'd0, misaligned}, 32'd0);

    // LW then ADD, ack in first BUSY cycle
    issue(OPC_LOAD, 3'b010, 32'h0000_0100, 32'h0, 5'd8);
    step();
    issue(OPC_OP, 3'b000, 32'h0000_0077, 32'h0, 5'd9);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    check("b2b_stall", {31'd0, stall}, 32'd1);
    step();
    dmem_ack = 1'b0;
    check("b2b_lw_valid", {31'd0, valid_out}, 32'd1);
    check("b2b_lw_d", d_out, 32'hDEAD_BEEF);
    check("b2b_lw_rd", {27'd0, rd_out}, 32'd8);
    step();
    valid_in = 1'b0;
    check("b2b_add_valid", {31'd0, valid_out}, 32'd1);
    check("b2b_add_c", c_out, 32'h0000_0077);
    check("b2b_add_d", d_out, 32'd0);

    // Timeout after four BUSY cycles
    issue(OPC_LOAD, 3'b010, 32'h0000_0010, 32'h0, 5'd1);
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("to_req", {31'd0, dmem_req}, 32'd1);
      check("to_no_err", {31'd0, bus_err}, 32'd0);
      step();
    end
    check("to_err", {31'd0, bus_err}, 32'd1);
    check("to_req_drop", {31'd0, dmem_req}, 32'd0);
    check("to_valid", {31'd0, valid_out}, 32'd0);
    check("to_stall", {31'd0, stall}, 32'd0);
    step();
    check("to_err_end", {31'd0, bus_err}, 32'd0);

    // Reset while BUSY
    issue(OPC_LOAD, 3'b010, 32'h0000_0020, 32'h0, 5'd2);
    step();
    valid_in = 1'b0;
    check("rb_req", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rb_req_drop", {31'd0, dmem_req}, 32'd0);
    check("rb_stall", {31'd0, stall}, 32'd0);
    check("rb_addr", dmem_addr, 32'd0);
    check("rb_c", c_out, 32'd0);
    check("rb_be", {28'd0, dmem_be}, 32'd0);
    #2 rst = 1'b0;
    step();
    check("rb_idle", {30'd0, valid_out, dmem_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
